// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    // Redirect targets are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~XLEN'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            im_req_o;
    logic [XLEN-1:0] im_addr_o;
    logic            im_ready_i;
    logic [XLEN-1:0] im_data_i;

    modport master (
        output im_req_o,
        output im_addr_o,
        input  im_ready_i,
        input  im_data_i
    );

    modport slave (
        input  im_req_o,
        input  im_addr_o,
        output im_ready_i,
        output im_data_i
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold by default, bubble has priority over load.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    // Register update: reset, bubble (NOP, invalid), load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '{pc: '0, inst: NOP, valid: 1'b0};
        end else if (bubble) begin
            q <= '{pc: q.pc, inst: NOP, valid: 1'b0};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling and IF/ID.
// Optional: define FETCH_PERF_CNT_EN to add saturating stall/flush counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    target_pc_i,
    fetch_stage_if.master      im,
    output logic [XLEN-1:0]    id_pc_o,
    output logic [XLEN-1:0]    id_inst_o,
    output logic               id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]    stall_cnt_o,
    output logic [XLEN-1:0]    flush_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_DROP  = 2'(DROP);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic            req_q;
    logic            ifid_load, ifid_bubble;
    ifid_t           ifid_d, ifid_q;
    logic [XLEN-1:0] target_al;

    assign target_al = align_pc(target_pc_i);

    // Next-state, PC/redirect and IF/ID control decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        ifid_load   = 1'b0;
        ifid_d      = '{pc: pc_q, inst: im.im_data_i, valid: 1'b1};

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (flush_i) begin
                    pc_d = target_al;
                end
            end
            ST_FETCH: begin
                if (flush_i) begin
                    if (im.im_ready_i) begin
                        pc_d = target_al;
                    end else begin
                        redir_d = target_al;
                        state_d = ST_DROP;
                    end
                end else if (im.im_ready_i && !stall_i) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + XLEN'(32'd4);
                end
            end
            ST_DROP: begin
                if (flush_i) begin
                    redir_d = target_al;
                end
                if (im.im_ready_i) begin
                    pc_d    = flush_i ? target_al : redir_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush always empties IF/ID; otherwise an unproductive unstalled cycle inserts a bubble.
        ifid_bubble = flush_i || (state_q != ST_IDLE && !stall_i && !ifid_load);
    end

    // State, PC, redirect and request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            redir_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            req_q   <= (state_d != ST_IDLE);
        end
    end

    ifid_reg u_ifid_reg (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign im.im_req_o  = req_q;
    assign im.im_addr_o = pc_q;
    assign id_pc_o      = ifid_q.pc;
    assign id_inst_o    = ifid_q.inst;
    assign id_valid_o   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(32'd1);
            end
            if (flush_i && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + XLEN'(32'd1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage, plus a wrap-around instance at PC_RESET=0xFFFF_FFFC.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic [31:0] key;
    logic [31:0] id_pc, id_inst;
    logic        id_valid;
    logic [31:0] id_pc2, id_inst2;
    logic        id_valid2;
    logic        stall2, flush2;
    logic [31:0] tgt2;

    int n_checks = 0;
    int n_errors = 0;

    ifid_t exp_q[$];
    logic  held_s, rst_s;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

    fetch_stage dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .flush_i     (flush),
        .target_pc_i (tgt),
        .im          (bus),
        .id_pc_o     (id_pc),
        .id_inst_o   (id_inst),
        .id_valid_o  (id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall2),
        .flush_i     (flush2),
        .target_pc_i (tgt2),
        .im          (bus2),
        .id_pc_o     (id_pc2),
        .id_inst_o   (id_inst2),
        .id_valid_o  (id_valid2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt2),
        .flush_cnt_o (flush_cnt2)
`endif
    );

    // Memory model: word returned is the address scrambled by a per-phase key.
    assign bus.im_data_i  = bus.im_addr_o ^ key;
    assign bus2.im_data_i = bus2.im_addr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, inst: pc ^ key, valid: 1'b1});
    endtask

    // Remember what the DUT saw at the edge: a stalled or reset edge cannot produce a new entry.
    always @(posedge clk) begin
        held_s = stall;
        rst_s  = rst;
    end

    // Compare each newly loaded valid IF/ID entry against the scoreboard.
    always @(negedge clk) begin
        if (!rst_s && !held_s && id_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                ifid_t e;
                e = exp_q.pop_front();
                check_eq("sb_pc", id_pc, e.pc);
                check_eq("sb_inst", id_inst, e.inst);
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; tgt = '0; key = '0;
        bus.im_ready_i = 1'b0;
        stall2 = 1'b0; flush2 = 1'b0; tgt2 = '0;
        bus2.im_ready_i = 1'b1;
        held_s = 1'b0; rst_s = 1'b1;
        repeat (3) tick();

        check_eq("rst_req", 32'(bus.im_req_o), 32'd0);
        check_eq("rst_addr", bus.im_addr_o, 32'h0);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_id_inst", id_inst, 32'h0000_0013);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_wrap_addr", bus2.im_addr_o, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);
        check_eq("rst_flush_cnt", flush_cnt, 32'd0);
`endif

        // Straight-line fetch with ready tied high.
        rst = 1'b0;
        bus.im_ready_i = 1'b1;
        check_eq("idle_req", 32'(bus.im_req_o), 32'd0);
        exp_push(32'h0);
        exp_push(32'h4);
        tick();
        check_eq("fetch_req", 32'(bus.im_req_o), 32'd1);
        check_eq("fetch_addr0", bus.im_addr_o, 32'h0);
        check_eq("fetch_valid0", 32'(id_valid), 32'd0);
        check_eq("wrap_first", bus2.im_addr_o, 32'hFFFF_FFFC);
        tick();
        check_eq("fetch_addr4", bus.im_addr_o, 32'h4);
        check_eq("wrap_second", bus2.im_addr_o, 32'h0);
        check_eq("wrap_id_pc", id_pc2, 32'hFFFF_FFFC);
        check_eq("wrap_id_valid", 32'(id_valid2), 32'd1);
        tick();
        check_eq("fetch_addr8", bus.im_addr_o, 32'h8);

        // Two stall cycles at pc=0x8.
        exp_push(32'h8);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("stall_id_pc", id_pc, 32'h4);
            check_eq("stall_addr", bus.im_addr_o, 32'h8);
        end
        stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt, 32'd2);
`endif
        tick();
        check_eq("resume_addr", bus.im_addr_o, 32'hC);

        // Flush with ready: unaligned target gets aligned.
        flush = 1'b1; tgt = 32'h103;
        tick();
        flush = 1'b0;
        check_eq("flush_addr", bus.im_addr_o, 32'h100);
        check_eq("flush_inst", id_inst, 32'h0000_0013);
        check_eq("flush_valid", 32'(id_valid), 32'd0);
        key = 32'hCAFE_0000;
        exp_push(32'h100);
        tick();
        check_eq("post_flush_addr", bus.im_addr_o, 32'h104);

        // Flush without ready: DROP for three unready cycles, then redirect.
        flush = 1'b1; tgt = 32'h40; bus.im_ready_i = 1'b0;
        tick();
        flush = 1'b0;
        check_eq("drop_state", 32'(dut.state_q), 32'(DROP));
        check_eq("drop_addr", bus.im_addr_o, 32'h104);
        check_eq("drop_req", 32'(bus.im_req_o), 32'd1);
        check_eq("drop_valid", 32'(id_valid), 32'd0);
        repeat (2) begin
            tick();
            check_eq("drop_hold_addr", bus.im_addr_o, 32'h104);
        end
        bus.im_ready_i = 1'b1;
        tick();
        check_eq("drop_exit_addr", bus.im_addr_o, 32'h40);
        check_eq("drop_exit_state", 32'(dut.state_q), 32'(FETCH));
        check_eq("drop_discard", 32'(id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("flush_cnt", flush_cnt, 32'd2);
`endif
        exp_push(32'h40);
        tick();

        // Stall and flush together: flush wins.
        stall = 1'b1; flush = 1'b1; tgt = 32'h200;
        tick();
        stall = 1'b0; flush = 1'b0;
        check_eq("sf_addr", bus.im_addr_o, 32'h200);
        check_eq("sf_valid", 32'(id_valid), 32'd0);
        check_eq("sf_inst", id_inst, 32'h0000_0013);
        exp_push(32'h200);
        tick();

        // Second flush while in DROP: last target wins.
        flush = 1'b1; tgt = 32'h300; bus.im_ready_i = 1'b0;
        tick();
        tgt = 32'h402;
        tick();
        flush = 1'b0; bus.im_ready_i = 1'b1;
        tick();
        check_eq("last_target", bus.im_addr_o, 32'h400);
        exp_push(32'h400);
        tick();

        // No response, no stall: bubble.
        bus.im_ready_i = 1'b0;
        tick();
        check_eq("bubble_valid", 32'(id_valid), 32'd0);
        check_eq("bubble_inst", id_inst, 32'h0000_0013);
        check_eq("bubble_addr", bus.im_addr_o, 32'h404);

        // No response with stall: IF/ID held.
        bus.im_ready_i = 1'b1;
        exp_push(32'h404);
        tick();
        bus.im_ready_i = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0;
        check_eq("hold_id_pc", id_pc, 32'h404);
        check_eq("hold_id_valid", 32'(id_valid), 32'd1);
        check_eq("hold_addr", bus.im_addr_o, 32'h408);

        // Reset while in DROP abandons the request.
        flush = 1'b1; tgt = 32'h500;
        tick();
        flush = 1'b0;
        rst = 1'b1; bus.im_ready_i = 1'b1;
        tick();
        check_eq("rst_drop_req", 32'(bus.im_req_o), 32'd0);
        check_eq("rst_drop_addr", bus.im_addr_o, 32'h0);
        check_eq("rst_drop_valid", 32'(id_valid), 32'd0);
        check_eq("rst_drop_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        tick();
        check_eq("restart_addr", bus.im_addr_o, 32'h0);
        check_eq("restart_valid", 32'(id_valid), 32'd0);
        exp_push(32'h0);
        tick();
        bus.im_ready_i = 1'b0;
        repeat (2) tick();

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, meaning reset, synchronous and active-high.
REQ-004 The block SHALL have port stall_i, input, 1, meaning load-use stall from the hazard unit.
REQ-005 The block SHALL have port flush_i, input, 1, meaning taken branch/jump in EXE.
REQ-006 The block SHALL have port target_pc_i, input, 32, meaning the redirect address, valid when flush_i=1.
REQ-007 The block SHALL have port im_req_o, output, 1, meaning instruction-memory request.
REQ-008 The block SHALL have port im_addr_o, output, 32, meaning the fetch address.
REQ-009 The block SHALL have port im_ready_i, input, 1, meaning im_data_i is valid this cycle.
REQ-010 The block SHALL have port im_data_i, input, 32, meaning the instruction word.
REQ-011 The block SHALL have port id_pc_o, output, 32, meaning the IF/ID register PC.
REQ-012 The block SHALL have port id_inst_o, output, 32, meaning the IF/ID register instruction.
REQ-013 The block SHALL have port id_valid_o, output, 1, meaning the IF/ID register holds a real instruction.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH and DROP; IDLE SHALL go to FETCH unconditionally one cycle after reset is released.
REQ-015 In IDLE, im_req_o SHALL be 0; in FETCH and DROP, im_req_o SHALL be 1 and im_addr_o SHALL be held stable until im_ready_i=1.
REQ-016 In FETCH with im_ready_i=1, flush_i=0 and stall_i=0, IF/ID SHALL load {pc, im_data_i, valid=1} and pc SHALL become pc+4 (mod 2^32, wrapping 0xFFFF_FFFC to 0x0000_0000).
REQ-017 In FETCH with im_ready_i=1 and stall_i=1 (flush_i=0), the returned word SHALL be discarded and pc and IF/ID held, so the same address is re-fetched.
REQ-018 In FETCH with im_ready_i=0, stall_i=0 and flush_i=0, IF/ID SHALL load a bubble: inst=NOP 32'h0000_0013, valid=0, pc unchanged; with stall_i=1, IF/ID SHALL be held.
REQ-019 In FETCH with flush_i=1 and im_ready_i=1, the word SHALL be discarded, pc SHALL take target_pc_i, and the FSM SHALL stay in FETCH.
REQ-020 In FETCH with flush_i=1 and im_ready_i=0, target_pc_i SHALL be captured into a redirect register and the FSM SHALL go to DROP.
REQ-021 In DROP, the outstanding request SHALL be completed and its response discarded; on im_ready_i=1, pc SHALL take the redirect register and the FSM SHALL go to FETCH.
REQ-022 A flush_i arriving in DROP SHALL overwrite the redirect register (last target wins).
REQ-023 On flush_i=1 in any state, the next-cycle IF/ID SHALL be NOP with valid=0, and flush_i SHALL take priority over stall_i.
REQ-024 Bits [1:0] of target_pc_i SHALL be forced to 0 on capture.
REQ-025 Latency: request issued in cycle N with ready in cycle N SHALL appear on id_*_o in cycle N+1.

Reset
REQ-026 While rst_i=1, the block SHALL set state=IDLE, pc=PC_RESET, redirect=0, im_req_o=0, id_pc_o=0, id_inst_o=NOP, id_valid_o=0, and counters to 0.
REQ-027 Reset asserted in DROP or FETCH SHALL abandon the outstanding request, with no IF/ID update from its response.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt_o[31:0] (cycles with stall_i=1) and flush_cnt_o[31:0] (cycles with flush_i=1), both saturating at 0xFFFF_FFFF.
REQ-029 Without FETCH_PERF_CNT_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The shared package SHALL hold the NOP constant, the fetch_state_e enum (IDLE/FETCH/DROP), and the ifid_t struct {pc, inst, valid}.
REQ-031 The block SHALL use one sub-module, ifid_reg, holding the IF/ID register with hold/bubble/load controls; the FSM and PC logic SHALL stay in fetch_stage.

Verification
REQ-032 Scenario: reset, then im_ready_i tied 1 and im_data_i=addr -> id_pc_o sequence 0x0, 0x4, 0x8 with id_valid_o=1 from cycle 2.
REQ-033 Scenario: stall_i=1 for 2 cycles at pc=0x8 -> id_pc_o holds 0x4 and im_addr_o holds 0x8, then resumes at 0x8.
REQ-034 Scenario: flush_i=1, target_pc_i=0x103, im_ready_i=1 -> next im_addr_o=0x100, id_inst_o=0x0000_0013, id_valid_o=0.
REQ-035 Scenario: flush_i=1 (target 0x40) with im_ready_i=0 for 3 cycles -> state DROP, im_addr_o held at old pc, response discarded, next fetch 0x40.
REQ-036 Scenario: stall_i=1 and flush_i=1 together -> flush behaviour, with stall ignored.
REQ-037 Scenario: PC_RESET=0xFFFF_FFFC with ready=1 -> second fetch address 0x0000_0000.
